// File: rtl/load_store_unit.sv
// Load/store unit: accepts one pipeline memory request at a time, checks alignment,
// drives the data-memory strobes and holds the response until the pipeline takes it.
module load_store_unit #(
    parameter int MEM_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        mem_w_en,
    output logic        mem_r_en,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_rw_type,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        busy
);
    localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [2:0]    type_q, type_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          fault_q, fault_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic is_illegal(input logic we, input logic [31:0] a, input logic [2:0] t);
        logic bad;
        case (t[1:0])
            2'b11:   bad = 1'b1;
            2'b01:   bad = a[0];
            2'b10:   bad = (a[1:0] != 2'b00) || t[2];
            default: bad = 1'b0;
        endcase
        return bad | (we & t[2]);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            type_q  <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        type_d  = type_q;
        wdata_d = wdata_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d    = req_we;
                addr_d  = req_addr;
                type_d  = req_type;
                wdata_d = req_wdata;
                rdata_d = '0;
                fault_d = is_illegal(req_we, req_addr, req_type);
                state_d = fault_d ? RESP : ACCESS;
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d = CW'(MEM_LAT);
                    if (MEM_LAT == 0) begin
                        rdata_d = mem_dout;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Counter enters at MEM_LAT; data is valid in the cycle it reads 1.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    rdata_d = mem_dout;
                    state_d = RESP;
                end
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == IDLE);
        busy        = (state_q != IDLE);
        rsp_valid   = (state_q == RESP);
        rsp_rdata   = (state_q == RESP) ? rdata_q : '0;
        rsp_fault   = (state_q == RESP) & fault_q;
        mem_w_en    = (state_q == ACCESS) & we_q;
        mem_r_en    = ((state_q == ACCESS) & ~we_q) | (state_q == WAIT);
        mem_addr    = addr_q;
        mem_rw_type = type_q;
        mem_din     = we_q ? wdata_q : '0;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: two instances (MEM_LAT=0 and MEM_LAT=3) share stimulus; a
// vector table covers loads/stores/faults, hand sequences cover backpressure and reset.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_type;

    logic        o_rdy [2];
    logic        o_rv  [2];
    logic [31:0] o_rd  [2];
    logic        o_flt [2];
    logic        o_we  [2];
    logic        o_re  [2];
    logic [31:0] o_addr[2];
    logic [2:0]  o_typ [2];
    logic [31:0] o_din [2];
    logic [31:0] m_dout[2];
    logic        o_busy[2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        if (a == 32'h2)  return 32'h0000CAFE;
        return 32'h12345678 ^ a;
    endfunction

    assign m_dout[0] = mem_rd(o_addr[0]);
    assign m_dout[1] = mem_rd(o_addr[1]);

    load_store_unit #(.MEM_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(o_rdy[0]),
        .req_we(req_we), .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
        .rsp_valid(o_rv[0]), .rsp_ready(rsp_ready), .rsp_rdata(o_rd[0]), .rsp_fault(o_flt[0]),
        .mem_w_en(o_we[0]), .mem_r_en(o_re[0]), .mem_addr(o_addr[0]), .mem_rw_type(o_typ[0]),
        .mem_din(o_din[0]), .mem_dout(m_dout[0]), .busy(o_busy[0]));

    load_store_unit #(.MEM_LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(o_rdy[1]),
        .req_we(req_we), .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
        .rsp_valid(o_rv[1]), .rsp_ready(rsp_ready), .rsp_rdata(o_rd[1]), .rsp_fault(o_flt[1]),
        .mem_w_en(o_we[1]), .mem_r_en(o_re[1]), .mem_addr(o_addr[1]), .mem_rw_type(o_typ[1]),
        .mem_din(o_din[1]), .mem_dout(m_dout[1]), .busy(o_busy[1]));

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  typ;
        logic [31:0] wdata;
        logic        fault;
        logic [31:0] rdata;
        logic [31:0] din;
        int          lat0;
        int          lat3;
        int          rd0;
        int          rd3;
        int          wr;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [2:0] t, input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_type  = t;
        req_wdata = wd;
    endtask

    // Issue one request (accepted at posedge of cycle 0) and observe cycles 1..9.
    task automatic run(input vec_t v, input int idx);
        int          lat [2];
        int          rdn [2];
        int          wrn [2];
        logic [31:0] rdv [2];
        logic        flt [2];
        logic [31:0] cad [2];
        logic [31:0] cty [2];
        logic [31:0] cdi [2];
        logic        stable;
        logic        seen;
        logic [31:0] a3;
        int          rd_exp;
        int          lat_exp;
        stable = 1'b1;
        seen = 1'b0;
        a3 = '0;
        for (int i = 0; i < 2; i++) begin
            lat[i] = -1; rdn[i] = 0; wrn[i] = 0; rdv[i] = '0; flt[i] = 1'b0;
            cad[i] = '0; cty[i] = '0; cdi[i] = '0;
        end
        @(negedge clk);
        drive(v.we, v.addr, v.typ, v.wdata);
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (o_rv[i] && lat[i] < 0) begin
                    lat[i] = c; rdv[i] = o_rd[i]; flt[i] = o_flt[i];
                end
                if (o_re[i]) rdn[i]++;
                if (o_we[i]) wrn[i]++;
                if (o_re[i] || o_we[i]) begin
                    cad[i] = o_addr[i]; cty[i] = 32'(o_typ[i]); cdi[i] = o_din[i];
                end
            end
            if (o_re[1]) begin
                if (seen && o_addr[1] != a3) stable = 1'b0;
                seen = 1'b1;
                a3 = o_addr[1];
            end
        end
        for (int i = 0; i < 2; i++) begin
            lat_exp = (i == 0) ? v.lat0 : v.lat3;
            rd_exp  = (i == 0) ? v.rd0 : v.rd3;
            chk($sformatf("v%0d.u%0d.latency", idx, i), 32'(lat[i]), 32'(lat_exp));
            chk($sformatf("v%0d.u%0d.rdata", idx, i), rdv[i], v.rdata);
            chk($sformatf("v%0d.u%0d.fault", idx, i), 32'(flt[i]), 32'(v.fault));
            chk($sformatf("v%0d.u%0d.r_en_cycles", idx, i), 32'(rdn[i]), 32'(rd_exp));
            chk($sformatf("v%0d.u%0d.w_en_cycles", idx, i), 32'(wrn[i]), 32'(v.wr));
            chk($sformatf("v%0d.u%0d.mem_addr", idx, i), cad[i], v.fault ? 32'h0 : v.addr);
            chk($sformatf("v%0d.u%0d.mem_type", idx, i), cty[i], v.fault ? 32'h0 : 32'(v.typ));
            chk($sformatf("v%0d.u%0d.mem_din", idx, i), cdi[i], v.din);
        end
        chk($sformatf("v%0d.u3.addr_stable", idx), 32'(stable), 32'h1);
        chk($sformatf("v%0d.idle_after", idx), {30'h0, o_rdy[1], o_rdy[0]}, 32'h3);
    endtask

    initial begin
        vec_t vt[11];
        logic hold_ok;
        logic rv_seen;

        vt[0]  = '{1'b0, 32'h10, 3'b010, 32'h0,        1'b0, 32'hDEADBEEF, 32'h0,        2, 5, 1, 4, 0};
        vt[1]  = '{1'b1, 32'h13, 3'b000, 32'hA5,       1'b0, 32'h0,        32'hA5,       2, 2, 0, 0, 1};
        vt[2]  = '{1'b0, 32'h21, 3'b001, 32'h0,        1'b1, 32'h0,        32'h0,        1, 1, 0, 0, 0};
        vt[3]  = '{1'b0, 32'h22, 3'b010, 32'h0,        1'b1, 32'h0,        32'h0,        1, 1, 0, 0, 0};
        vt[4]  = '{1'b0, 32'h0,  3'b011, 32'h0,        1'b1, 32'h0,        32'h0,        1, 1, 0, 0, 0};
        vt[5]  = '{1'b0, 32'h2,  3'b101, 32'h0,        1'b0, 32'h0000CAFE, 32'h0,        2, 5, 1, 4, 0};
        vt[6]  = '{1'b0, 32'h4,  3'b110, 32'h0,        1'b1, 32'h0,        32'h0,        1, 1, 0, 0, 0};
        vt[7]  = '{1'b1, 32'h8,  3'b100, 32'hFF,       1'b1, 32'h0,        32'h0,        1, 1, 0, 0, 0};
        vt[8]  = '{1'b1, 32'h40, 3'b010, 32'h11223344, 1'b0, 32'h0,        32'h11223344, 2, 2, 0, 0, 1};
        vt[9]  = '{1'b0, 32'h7,  3'b000, 32'h0,        1'b0, 32'h1234567F, 32'h0,        2, 5, 1, 4, 0};
        vt[10] = '{1'b1, 32'h6,  3'b001, 32'hFFFFBEEF, 1'b0, 32'h0,        32'hFFFFBEEF, 2, 2, 0, 0, 1};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_type = '0; req_wdata = '0; rsp_ready = 1'b1;
        #12;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset.u%0d.ready_busy_rv", i), {29'h0, o_rdy[i], o_busy[i], o_rv[i]}, 32'h4);
            chk($sformatf("reset.u%0d.strobes_fault", i), {29'h0, o_we[i], o_re[i], o_flt[i]}, 32'h0);
            chk($sformatf("reset.u%0d.addr_rdata_din", i), o_addr[i] | o_rd[i] | o_din[i] | 32'(o_typ[i]), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 11; k++) run(vt[k], k);

        // Backpressure: response held for 10 cycles, new requests ignored meanwhile.
        rsp_ready = 1'b0;
        @(negedge clk);
        drive(1'b0, 32'h10, 3'b010, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
        end
        hold_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 32'h40, 3'b010, 32'h55);
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 2; i++)
                if (!o_rv[i] || o_rd[i] != 32'hDEADBEEF || o_rdy[i] || o_flt[i] || o_we[i] || o_re[i])
                    hold_ok = 1'b0;
        end
        chk("hold.stable_10_cycles", 32'(hold_ok), 32'h1);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold.release_idle", {28'h0, o_rdy[1], o_rdy[0], o_rv[1], o_rv[0]}, 32'hC);
        rv_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_rv[0] || o_rv[1] || o_we[0] || o_we[1]) rv_seen = 1'b1;
        end
        chk("hold.ignored_req_no_activity", 32'(rv_seen), 32'h0);

        // Reset asserted mid-WAIT on the MEM_LAT=3 instance.
        @(negedge clk);
        drive(1'b0, 32'h10, 3'b010, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
        end
        chk("rstwait.pre_r_en_busy", {30'h0, o_re[1], o_busy[1]}, 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstwait.async_drop", {28'h0, o_re[1], o_busy[1], o_rv[1], o_rdy[1]}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        rv_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_rv[0] || o_rv[1] || o_re[1] || !o_rdy[1]) rv_seen = 1'b1;
        end
        chk("rstwait.no_response_after", 32'(rv_seen), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_LAT, default 0, data-memory read latency in cycles after the first cycle mem_r_en is high (0 = combinational read).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  pipeline memory request present.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_type  input  3  [1:0] size (00 byte, 01 half, 10 word); [2] unsigned load.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  pipeline consumes response.
REQ-012 rsp_rdata  output  32  load result, already extended by memory.
REQ-013 rsp_fault  output  1  request rejected as misaligned or illegal.
REQ-014 mem_w_en, mem_r_en  output  1 each  memory write/read strobes.
REQ-015 mem_addr  output  32; mem_rw_type  output  3; mem_din  output  32  memory request fields.
REQ-016 mem_dout  input  32  memory read data.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-019 IDLE: on req_valid, latch we/addr/type/wdata; go to RESP with fault if illegal, else ACCESS.
REQ-020 Illegal: size 11; half with addr[0]=1; word with addr[1:0]!=00; word with type[2]=1; store with type[2]=1.
REQ-021 Faulted requests SHALL never assert mem_w_en or mem_r_en; rsp_fault=1, rsp_rdata=0.
REQ-022 mem_addr, mem_rw_type, mem_din SHALL be driven from latched registers and held stable from ACCESS through the last WAIT cycle.
REQ-023 mem_din = latched wdata for stores, 0 for loads; no lane shifting (memory merges lanes).
REQ-024 ACCESS (store): mem_w_en high for exactly one cycle, then RESP with rsp_rdata=0, rsp_fault=0.
REQ-025 ACCESS (load): mem_r_en high; latency counter loaded with MEM_LAT; MEM_LAT=0 samples mem_dout at end of ACCESS and goes to RESP, else goes to WAIT.
REQ-026 WAIT: mem_r_en held high; counter decrements each cycle; mem_dout sampled at end of the cycle counter equals 1, then RESP.
REQ-027 Latency from acceptance cycle (cycle 0): rsp_valid first high at cycle 2+MEM_LAT for loads, cycle 2 for stores, cycle 1 for faults.
REQ-028 RESP: rsp_valid=1; rsp_rdata and rsp_fault held constant until rsp_ready=1; then IDLE next cycle.
REQ-029 No request SHALL be accepted during the cycle RESP is exited; minimum request spacing = response latency + 1.
REQ-030 req_valid outside IDLE SHALL be ignored and not latched.
REQ-031 Counter width SHALL hold MEM_LAT without wrap; MEM_LAT up to 255.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE and all outputs to 0 except req_ready=1; strobes drop without waiting for clk.
REQ-033 Reset mid-ACCESS/WAIT/RESP SHALL discard the in-flight request; no response is issued after release.

Verification
REQ-034 MEM_LAT=0, load word addr 0x10 holding 0xDEADBEEF -> rsp_valid at cycle 2, rsp_rdata=0xDEADBEEF, one-cycle mem_r_en.
REQ-035 Store byte 0xA5 at 0x13 (type 000) -> one mem_w_en pulse with mem_addr=0x13, mem_rw_type=000, mem_din=0x000000A5; rsp_valid at cycle 2, rsp_rdata=0.
REQ-036 Load half at 0x21 -> rsp_fault=1 at cycle 1, no memory strobe; repeat for word at 0x22 and type 011.
REQ-037 MEM_LAT=3, load half-unsigned at 0x2 -> mem_r_en high 4 cycles, address stable, rsp_valid at cycle 5.
REQ-038 rsp_ready held low 10 cycles in RESP -> rsp_valid/rsp_rdata constant, req_ready=0, new req_valid ignored.
REQ-039 rst_n low during WAIT -> mem_r_en and busy drop immediately; after release req_ready=1, no rsp_valid.
